// File: rtl/port_sum_checker_if.sv
// Purpose: bundles the observed adder-port sample stream, the restart request and the checker status.
// Latency: none (signal bundle only).
// Backpressure: none; samples are one-cycle strobes with no ready path.
// Ports: master = bench/driver side (drives inPort/inValid/clr, reads status);
//        slave  = checker side (reads sample/clr, drives status).
interface port_sum_checker_if #(
  parameter int DW = 8
);
  logic [DW-1:0] inPort;
  logic          inValid;
  logic          clr;
  logic          busy;
  logic          done;
  logic          error;
  logic          overrun;
  logic [3:0]    matchCount;
  logic [DW-1:0] lastData;
  logic [DW-1:0] errExpected;

  modport master (
    output inPort, inValid, clr,
    input  busy, done, error, overrun, matchCount, lastData, errExpected
  );

  modport slave (
    input  inPort, inValid, clr,
    output busy, done, error, overrun, matchCount, lastData, errExpected
  );
endinterface

// File: rtl/port_sum_checker.sv
// Purpose: checks that an adder's output port emits the running sums 0, 1, 3, ..., sum(0..LIMIT).
// Latency: every status output reflects a sample one clk edge after its inValid cycle.
// Backpressure: none; every inValid strobe is consumed (compared, flagged or ignored by state).
// Ports: clk, rst (async, active-high); bus (slave modport): inPort/inValid sample strobe,
//        clr restart; busy/done/error/overrun flags, matchCount, lastData, errExpected.
module port_sum_checker #(
  parameter int LIMIT = 10,  // final term index, 1..15
  parameter int DW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  port_sum_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [3:0] LAST_N = 4'(LIMIT);

  state_t        state;
  logic [DW-1:0] expected;
  logic [3:0]    n;
  logic [3:0]    match_count;
  logic [DW-1:0] last_data;
  logic [DW-1:0] err_expected;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic          overrun_q;

  // Status flags are flopped alongside the state so each equals the decode
  // of the state register without any combinational path from inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      expected     <= '0;
      n            <= '0;
      match_count  <= '0;
      last_data    <= '0;
      err_expected <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (bus.clr) begin
      // Restart wins over any sample in the same cycle; lastData is kept.
      state        <= S_TRACK;
      expected     <= '0;
      n            <= '0;
      match_count  <= '0;
      err_expected <= '0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state  <= S_TRACK;
          busy_q <= 1'b1;
        end

        S_TRACK: begin
          if (bus.inValid) begin
            last_data <= bus.inPort;
            if (bus.inPort == expected) begin
              // With LIMIT=15 there are 16 correct samples; the 4-bit count
              // saturates at 15 instead of wrapping to 0.
              if (match_count != 4'hF) begin
                match_count <= match_count + 4'd1;
              end
              n        <= n + 4'd1;
              expected <= expected + DW'(n) + DW'(1);
              if (n == LAST_N) begin
                state  <= S_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end else begin
              err_expected <= expected;
              state        <= S_ERROR;
              busy_q       <= 1'b0;
              error_q      <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (bus.inValid) begin
            overrun_q <= 1'b1;
          end
        end

        default: begin
          // S_ERROR: frozen until clr or rst.
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.overrun     = overrun_q;
  assign bus.matchCount  = match_count;
  assign bus.lastData    = last_data;
  assign bus.errExpected = err_expected;

endmodule

// File: tb/tb_port_sum_checker.sv
module tb_port_sum_checker;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       error;
    logic       overrun;
    logic [3:0] mcnt;
    logic [7:0] last;
    logic [7:0] errexp;
  } obs_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  port_sum_checker_if #(.DW(8)) ba ();
  port_sum_checker_if #(.DW(8)) bb ();

  port_sum_checker #(.LIMIT(10), .DW(8)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  port_sum_checker #(.LIMIT(15), .DW(8)) dut_b (.clk(clk), .rst(rst), .bus(bb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for dut_a: mode 0=TRACK 1=DONE 2=ERROR 3=IDLE/reset.
  int         m_mode   = 3;
  int         m_cnt    = 0;
  logic [7:0] m_last   = '0;
  logic [7:0] m_errexp = '0;
  logic       m_ovr    = 1'b0;
  obs_t       sb[$];

  function automatic logic [7:0] tri_n(input int k);
    return 8'((k * (k + 1)) / 2);
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.busy = ba.busy; o.done = ba.done; o.error = ba.error; o.overrun = ba.overrun;
    o.mcnt = ba.matchCount; o.last = ba.lastData; o.errexp = ba.errExpected;
    return o;
  endfunction

  function automatic obs_t model_a();
    obs_t o;
    o.busy    = (m_mode == 0);
    o.done    = (m_mode == 1);
    o.error   = (m_mode == 2);
    o.overrun = m_ovr;
    o.mcnt    = (m_cnt > 15) ? 4'd15 : 4'(m_cnt);
    o.last    = m_last;
    o.errexp  = m_errexp;
    return o;
  endfunction

  // One stimulus cycle on dut_a; the expected state is queued when driven
  // and compared one edge later when the DUT has registered it.
  task automatic pulse_a(input string name, input logic [7:0] v,
                         input logic valid, input logic clear);
    obs_t e;
    obs_t got;
    @(negedge clk);
    ba.inPort = v; ba.inValid = valid; ba.clr = clear;
    if (clear) begin
      m_mode = 0; m_cnt = 0; m_ovr = 1'b0; m_errexp = '0;
    end else if (valid) begin
      case (m_mode)
        0: begin
          m_last = v;
          if (v == tri_n(m_cnt)) begin
            m_cnt++;
            if (m_cnt == 11) m_mode = 1;
          end else begin
            m_errexp = tri_n(m_cnt);
            m_mode   = 2;
          end
        end
        1: m_ovr = 1'b1;
        default: ;
      endcase
    end
    sb.push_back(model_a());
    @(posedge clk);
    #1;
    ba.inValid = 1'b0; ba.clr = 1'b0;
    e   = sb.pop_front();
    got = obs_a();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b err=%b ovr=%b cnt=%0d last=%0d errexp=%0d want busy=%b done=%b err=%b ovr=%b cnt=%0d last=%0d errexp=%0d",
               name, got.busy, got.done, got.error, got.overrun, got.mcnt, got.last, got.errexp,
               e.busy, e.done, e.error, e.overrun, e.mcnt, e.last, e.errexp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic run_seq_a(input int count, input int maxgap);
    for (int k = 0; k < count; k++) begin
      pulse_a("seq", tri_n(k), 1'b1, 1'b0);
      gap($urandom_range(1, maxgap));
    end
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b1;
    m_mode = 3; m_cnt = 0; m_last = '0; m_errexp = '0; m_ovr = 1'b0;
    gap(2);
    #1;
    got = obs_a();
    checks++;
    if (got !== model_a()) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", got, model_a());
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_mode = 0;
    checks++;
    if (ba.busy !== 1'b1 || bb.busy !== 1'b1) begin
      errors++;
      $display("FAIL idle_to_track: got busy a=%b b=%b want 1", ba.busy, bb.busy);
    end
  endtask

  task automatic test_nominal();
    run_seq_a(11, 5);
    checks++;
    if (ba.done !== 1'b1 || ba.matchCount !== 4'd11 || ba.lastData !== 8'd55 || ba.error !== 1'b0) begin
      errors++;
      $display("FAIL nominal_end: got done=%b cnt=%0d last=%0d err=%b want done=1 cnt=11 last=55 err=0",
               ba.done, ba.matchCount, ba.lastData, ba.error);
    end
  endtask

  task automatic test_overrun();
    pulse_a("overrun", 8'd66, 1'b1, 1'b0);
    checks++;
    if (ba.overrun !== 1'b1 || ba.done !== 1'b1 || ba.lastData !== 8'd55) begin
      errors++;
      $display("FAIL overrun_flags: got ovr=%b done=%b last=%0d want ovr=1 done=1 last=55",
               ba.overrun, ba.done, ba.lastData);
    end
  endtask

  task automatic test_mismatch();
    pulse_a("clr_from_done", 8'd0, 1'b0, 1'b1);
    run_seq_a(3, 2);
    pulse_a("mismatch", 8'd7, 1'b1, 1'b0);
    checks++;
    if (ba.error !== 1'b1 || ba.errExpected !== 8'd6 || ba.lastData !== 8'd7 ||
        ba.matchCount !== 4'd3 || ba.busy !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_flags: got err=%b errexp=%0d last=%0d cnt=%0d busy=%b want 1 6 7 3 0",
               ba.error, ba.errExpected, ba.lastData, ba.matchCount, ba.busy);
    end
    pulse_a("error_frozen", 8'd10, 1'b1, 1'b0);
    pulse_a("error_frozen2", 8'd6, 1'b1, 1'b0);
  endtask

  task automatic test_clr_collision();
    pulse_a("clr_from_error", 8'd0, 1'b0, 1'b1);
    run_seq_a(2, 3);
    pulse_a("clr_with_valid", 8'd3, 1'b1, 1'b1);
    checks++;
    if (ba.matchCount !== 4'd0 || ba.busy !== 1'b1 || ba.lastData !== 8'd1) begin
      errors++;
      $display("FAIL clr_collision: got cnt=%0d busy=%b last=%0d want cnt=0 busy=1 last=1",
               ba.matchCount, ba.busy, ba.lastData);
    end
    pulse_a("after_clr_zero", 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    obs_t got;
    pulse_a("clr_pre_async", 8'd0, 1'b0, 1'b1);
    run_seq_a(4, 2);
    #2;
    rst = 1'b1;
    m_mode = 3; m_cnt = 0; m_last = '0; m_errexp = '0; m_ovr = 1'b0;
    #1;
    got = obs_a();
    checks++;
    if (got !== model_a() || bb.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h b_busy=%b want %h b_busy=0", got, bb.busy, model_a());
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_mode = 0;
    pulse_a("post_reset_zero", 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_limit15();
    int accepted;
    int done_at;
    accepted = 0;
    done_at  = -1;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      bb.inPort = tri_n(k); bb.inValid = 1'b1;
      @(posedge clk);
      #1;
      bb.inValid = 1'b0;
      accepted++;
      if (bb.done === 1'b1 && done_at < 0) done_at = accepted;
      checks++;
      if (bb.matchCount !== ((k + 1 > 15) ? 4'd15 : 4'(k + 1)) || bb.done !== (k == 15) || bb.error !== 1'b0) begin
        errors++;
        $display("FAIL limit15_step%0d: got cnt=%0d done=%b err=%b want cnt=%0d done=%b err=0",
                 k, bb.matchCount, bb.done, bb.error, (k + 1 > 15) ? 15 : k + 1, (k == 15));
      end
      gap($urandom_range(1, 3));
    end
    checks++;
    if (done_at != 16 || bb.lastData !== 8'd120) begin
      errors++;
      $display("FAIL limit15_count: got samples_to_done=%0d last=%0d want 16 last=120", done_at, bb.lastData);
    end
  endtask

  initial begin
    rst = 1'b1;
    ba.inPort = '0; ba.inValid = 1'b0; ba.clr = 1'b0;
    bb.inPort = '0; bb.inValid = 1'b0; bb.clr = 1'b0;
    test_reset();
    test_nominal();
    test_overrun();
    test_mismatch();
    test_clr_collision();
    test_async_reset();
    test_limit15();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
